// File: rtl/multi_cycle_adder.sv
// Serial add/subtract: one CHUNK-bit slice per cycle across a WIDTH-bit operand pair.
// Latency: WIDTH/CHUNK cycles from accept to out_valid. Throughput: one op per N+2 cycles.
// Backpressure: accepts only in IDLE; results hold in DONE until out_ready.
module multi_cycle_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cIn,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
   logic             carry_q;
   logic [KW-1:0]    k_q;
   logic [CHUNK-1:0] a_ch, b_ch, s_ch;
   logic [CHUNK:0]   tot;
   logic             co_ch, cin_top, last, accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (k_q == KW'(N - 1));

   // Slice select and write-back use constant indices so any CHUNK/WIDTH pair elaborates cleanly.
   always_comb begin
      a_ch = '0;
      b_ch = '0;
      for (int i = 0; i < N; i++) begin
         if (k_q == KW'(i)) begin
            a_ch = a_q[i*CHUNK +: CHUNK];
            b_ch = b_q[i*CHUNK +: CHUNK];
         end
      end
      tot     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
      s_ch    = tot[CHUNK-1:0];
      co_ch   = tot[CHUNK];
      // Carry into the top bit of this slice; on the last slice it is the carry into the MSB.
      cin_top = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
      res_nxt = res_q;
      for (int i = 0; i < N; i++) begin
         if (k_q == KW'(i)) begin
            res_nxt[i*CHUNK +: CHUNK] = s_ch;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last)     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         k_q      <= '0;
         sum      <= '0;
         c        <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (accept) begin
         a_q     <= in1;
         // Subtract as A + ~B + ~borrow_in.
         b_q     <= sub ? ~in2 : in2;
         carry_q <= cIn ^ sub;
         k_q     <= '0;
      end else if (state == RUN) begin
         res_q   <= res_nxt;
         carry_q <= co_ch;
         k_q     <= k_q + KW'(1);
         if (last) begin
            sum      <= res_nxt;
            c        <= co_ch;
            overflow <= cin_top ^ co_ch;
            zero     <= (res_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Random and directed bench for multi_cycle_adder across four WIDTH/CHUNK configurations.
module tb_multi_cycle_adder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] in1, in2;
   logic        cin, sub, out_ready;
   logic [3:0]  iv;

   logic        r0, r1, r2, r3, v0, v1, v2, v3;
   logic        c0, c1, c2, c3, f0, f1, f2, f3, z0, z1, z2, z3;
   logic [31:0] s0, s3;
   logic [7:0]  s1;
   logic [15:0] s2;

   logic [3:0]  ir, ov_vld, o_c, o_f, o_z;
   logic [31:0] o_sum [4];

   assign ir     = {r3, r2, r1, r0};
   assign ov_vld = {v3, v2, v1, v0};
   assign o_c    = {c3, c2, c1, c0};
   assign o_f    = {f3, f2, f1, f0};
   assign o_z    = {z3, z2, z1, z0};
   assign o_sum[0] = s0;
   assign o_sum[1] = {24'b0, s1};
   assign o_sum[2] = {16'b0, s2};
   assign o_sum[3] = s3;

   int cfg_w [4] = '{32, 8, 16, 32};
   int cfg_n [4] = '{4, 1, 4, 32};

   int total = 0;
   int bad   = 0;

   multi_cycle_adder #(.WIDTH(32), .CHUNK(8)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(r0), .in1(in1), .in2(in2),
      .cIn(cin), .sub(sub), .out_valid(v0), .out_ready(out_ready),
      .sum(s0), .c(c0), .overflow(f0), .zero(z0));
   multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(r1), .in1(in1[7:0]), .in2(in2[7:0]),
      .cIn(cin), .sub(sub), .out_valid(v1), .out_ready(out_ready),
      .sum(s1), .c(c1), .overflow(f1), .zero(z1));
   multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(r2), .in1(in1[15:0]), .in2(in2[15:0]),
      .cIn(cin), .sub(sub), .out_valid(v2), .out_ready(out_ready),
      .sum(s2), .c(c2), .overflow(f2), .zero(z2));
   multi_cycle_adder #(.WIDTH(32), .CHUNK(1)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(r3), .in1(in1), .in2(in2),
      .cIn(cin), .sub(sub), .out_valid(v3), .out_ready(out_ready),
      .sum(s3), .c(c3), .overflow(f3), .zero(z3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-width integer arithmetic, signed range test for overflow.
   function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input logic sb, output logic [31:0] es,
                                     output logic ec, output logic eo, output logic ez);
      longint mask, half, ua, ub, sa, sbv, t, sr;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sbv  = (ub >= half) ? ub - (mask + 1) : ub;
      if (!sb) begin
         t  = ua + ub + longint'(ci);
         ec = ((t >> w) & 1) != 0;
         sr = sa + sbv + longint'(ci);
      end else begin
         t  = ua - ub - longint'(ci);
         ec = (t >= 0);
         sr = sa - sbv - longint'(ci);
      end
      es = 32'(t & mask);
      eo = (sr >= half) || (sr < -half);
      ez = (es == 32'd0);
   endfunction

   function automatic logic [31:0] pick(input int w);
      logic [31:0] one;
      one = 32'd1;
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return one << (w - 1);
         3:       return (one << (w - 1)) - 32'd1;
         4:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez, input int hold);
      int n;
      logic seen;
      logic [31:0] held;
      n = 0;
      while (!ir[idx] && n < 200) begin
         tick();
         n++;
      end
      chk($sformatf("ready_wait%0d", idx), 32'(ir[idx]), 32'd1);
      in1 = a; in2 = b; cin = ci; sub = sb;
      out_ready = (hold == 0);
      iv[idx] = 1'b1;
      tick();
      iv[idx] = 1'b0;
      in1 = $urandom; in2 = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      chk($sformatf("busy%0d", idx), 32'(ir[idx]), 32'd0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         tick();
         n++;
         seen = ov_vld[idx];
      end
      chk($sformatf("latency%0d", idx), 32'(n), 32'(cfg_n[idx]));
      chk($sformatf("sum%0d", idx), o_sum[idx], es);
      chk($sformatf("c%0d", idx), 32'(o_c[idx]), 32'(ec));
      chk($sformatf("ovf%0d", idx), 32'(o_f[idx]), 32'(eo));
      chk($sformatf("zero%0d", idx), 32'(o_z[idx]), 32'(ez));
      if (hold > 0) begin
         held = o_sum[idx];
         for (int i = 0; i < hold; i++) begin
            in1 = $urandom; in2 = $urandom; iv[idx] = 1'b1;
            tick();
            chk("bp_valid", 32'(ov_vld[idx]), 32'd1);
            chk("bp_sum", o_sum[idx], held);
            chk("bp_ready", 32'(ir[idx]), 32'd0);
         end
         iv[idx] = 1'b0;
         out_ready = 1'b1;
      end
      tick();
      chk($sformatf("ret_ready%0d", idx), 32'(ir[idx]), 32'd1);
      chk($sformatf("ret_valid%0d", idx), 32'(ov_vld[idx]), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b, es;
      logic ci, sb, ec, eo, ez;
      int stray;
      rst = 1'b1; iv = '0; out_ready = 1'b1;
      in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rst_ready", 32'(ir[i]), 32'd1);
         chk("rst_valid", 32'(ov_vld[i]), 32'd0);
         chk("rst_sum", o_sum[i], 32'd0);
         chk("rst_c", 32'(o_c[i]), 32'd0);
         chk("rst_ovf", 32'(o_f[i]), 32'd0);
         chk("rst_zero", 32'(o_z[i]), 32'd0);
      end

      run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
      run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
      run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
      run_op(0, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
      run_op(0, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
      run_op(0, 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 3);

      // Reset during the second RUN cycle discards the operation.
      in1 = 32'h1234_5678; in2 = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(ov_vld[0]), 32'd0);
      chk("mid_rst_ready", 32'(ir[0]), 32'd1);
      chk("mid_rst_sum", o_sum[0], 32'd0);
      chk("mid_rst_c", 32'(o_c[0]), 32'd0);
      chk("mid_rst_ovf", 32'(o_f[0]), 32'd0);
      chk("mid_rst_zero", 32'(o_z[0]), 32'd0);
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ov_vld[0]) stray++;
      end
      chk("mid_rst_stray", 32'(stray), 32'd0);

      for (int idx = 0; idx < 4; idx++) begin
         for (int k = 0; k < 1000; k++) begin
            a  = pick(cfg_w[idx]);
            b  = pick(cfg_w[idx]);
            ci = 1'($urandom);
            sb = 1'($urandom);
            ref_model(cfg_w[idx], a, b, ci, sb, es, ec, eo, ez);
            run_op(idx, a, b, ci, sb, es, ec, eo, ez, (k % 97 == 5) ? 2 : 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
